// File: rtl/powerpc_rom_fetch.sv
// Fetch sequencer for the 16x4 boot ROM: owns the PC, hides the one-cycle
// read latency and hands nibbles to decode through a 2-entry buffer.
module powerpc_rom_fetch #(
  parameter bit STOP_AT_END = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] start_addr_i,
  input  logic       halt_i,
  input  logic       redirect_i,
  input  logic [3:0] redirect_addr_i,
  output logic       rom_en_o,
  output logic [3:0] rom_addr_o,
  input  logic [3:0] rom_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] out_data_o,
  output logic [3:0] out_addr_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic       infl_q, infl_d;
  logic [3:0] infl_addr_q, infl_addr_d;
  logic [1:0] count_q, count_d;
  logic [3:0] d0_q, d0_d, d1_q, d1_d;
  logic [3:0] a0_q, a0_d, a1_q, a1_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic [1:0] cnt_pop;

  assign pop     = (count_q != 2'd0) & out_ready_i;
  assign push    = infl_q;
  assign cnt_pop = count_q - {1'b0, pop};

  // Credit: buffered + in-flight after this edge's pop must leave a free slot
  assign occ   = {1'b0, count_q} + {2'b0, infl_q} - {2'b0, pop};
  assign issue = (state_q == RUN) && (occ < 3'd2);

  assign rom_en_o    = issue;
  assign rom_addr_o  = pc_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = d0_q;
  assign out_addr_o  = a0_q;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    infl_d      = infl_q;
    infl_addr_d = infl_addr_q;
    count_d     = count_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !halt_i) begin
          state_d = RUN;
          pc_d    = start_addr_i;
        end
      end
      RUN, DRAIN: begin
        if (redirect_i) begin
          count_d = 2'd0;
          infl_d  = 1'b0;
          pc_d    = redirect_addr_i;
          state_d = halt_i ? DRAIN : RUN;
        end else begin
          if (pop) begin
            d0_d = d1_q;
            a0_d = a1_q;
          end
          if (push) begin
            if (cnt_pop == 2'd0) begin
              d0_d = rom_data_i;
              a0_d = infl_addr_q;
            end else begin
              d1_d = rom_data_i;
              a1_d = infl_addr_q;
            end
          end
          count_d = cnt_pop + {1'b0, push};
          infl_d  = issue;
          if (issue) begin
            infl_addr_d = pc_q;
            pc_d        = pc_q + 4'd1;
          end
          if (state_q == RUN) begin
            if (halt_i)
              state_d = DRAIN;
            else if (STOP_AT_END && issue && (pc_q == 4'hF))
              state_d = DRAIN;
          end else if (count_d == 2'd0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pc_q        <= 4'd0;
      infl_q      <= 1'b0;
      infl_addr_q <= 4'd0;
      count_q     <= 2'd0;
      d0_q        <= 4'd0;
      d1_q        <= 4'd0;
      a0_q        <= 4'd0;
      a1_q        <= 4'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      count_q     <= count_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
    end
  end

endmodule

// File: tb/tb_powerpc_rom_fetch.sv
// Directed bench for powerpc_rom_fetch: two instances (wrap / stop-at-end)
// share stimulus, each backed by its own registered ROM model.
module tb_powerpc_rom_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic       halt;
  logic       redirect;
  logic [3:0] redirect_addr;
  logic       ready;

  logic       en0, en1;
  logic [3:0] ra0, ra1;
  logic [3:0] rd0, rd1;
  logic       ov0, ov1;
  logic [3:0] od0, od1;
  logic [3:0] oa0, oa1;
  logic       busy0, busy1;

  logic [3:0] mem [16];
  int pass_cnt;
  int total;

  powerpc_rom_fetch #(.STOP_AT_END(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_addr_i(start_addr),
    .halt_i(halt), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .rom_en_o(en0), .rom_addr_o(ra0), .rom_data_i(rd0),
    .out_valid_o(ov0), .out_ready_i(ready), .out_data_o(od0),
    .out_addr_o(oa0), .busy_o(busy0)
  );

  powerpc_rom_fetch #(.STOP_AT_END(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_addr_i(start_addr),
    .halt_i(halt), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .rom_en_o(en1), .rom_addr_o(ra1), .rom_data_i(rd1),
    .out_valid_o(ov1), .out_ready_i(ready), .out_data_o(od1),
    .out_addr_o(oa1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    mem[0]  = 4'h2; mem[1]  = 4'h2; mem[2]  = 4'hE; mem[3]  = 4'h2;
    mem[4]  = 4'h4; mem[5]  = 4'hA; mem[6]  = 4'hC; mem[7]  = 4'h0;
    mem[8]  = 4'h1; mem[9]  = 4'h3; mem[10] = 4'h5; mem[11] = 4'h7;
    mem[12] = 4'h9; mem[13] = 4'hB; mem[14] = 4'hC; mem[15] = 4'h0;
    rd0 = 4'h0;
    rd1 = 4'h0;
  end

  always @(posedge clk) begin
    if (en0) rd0 <= mem[ra0];
    if (en1) rd1 <= mem[ra1];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_to_idle;
    bit done;
    halt  = 1'b1;
    ready = 1'b1;
    done  = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (!busy0 && !busy1) done = 1'b1;
    end
    total++;
    if (!done) $display("FAIL drain_timeout busy0=%b busy1=%b want 0 0", busy0, busy1);
    else pass_cnt++;
    halt  = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    total++; if ({en0, ra0, ov0, od0, oa0, busy0} !== 14'd0)
      $display("FAIL rst_init got=%h want=0", {en0, ra0, ov0, od0, oa0, busy0}); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    start = 1'b1; start_addr = 4'd0; ready = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    total++; if (ov0 !== 1'b1) $display("FAIL rst_pre_valid got=%b want=1", ov0); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({en0, ra0, ov0, od0, oa0, busy0} !== 14'd0)
      $display("FAIL rst_async got=%h want=0", {en0, ra0, ov0, od0, oa0, busy0}); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream;
    logic [3:0] exp [8];
    exp[0] = 4'h2; exp[1] = 4'h2; exp[2] = 4'hE; exp[3] = 4'h2;
    exp[4] = 4'h4; exp[5] = 4'hA; exp[6] = 4'hC; exp[7] = 4'h0;
    ready = 1'b1; start_addr = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++; if (ov0 !== 1'b0) $display("FAIL st_early got=%b want=0", ov0); else pass_cnt++;
    tick();
    for (int i = 0; i < 8; i++) begin
      total++; if (ov0 !== 1'b1) $display("FAIL st_valid%0d got=%b want=1", i, ov0); else pass_cnt++;
      total++; if (od0 !== exp[i]) $display("FAIL st_data%0d got=%h want=%h", i, od0, exp[i]); else pass_cnt++;
      total++; if (oa0 !== 4'(i)) $display("FAIL st_addr%0d got=%h want=%h", i, oa0, 4'(i)); else pass_cnt++;
      tick();
    end
    drain_to_idle();
  endtask

  task automatic test_backpressure;
    int pulses;
    ready = 1'b0; start_addr = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (en0) pulses++;
      tick();
    end
    total++; if (pulses != 2) $display("FAIL bp_pulses got=%0d want=2", pulses); else pass_cnt++;
    total++; if (en0 !== 1'b0) $display("FAIL bp_en_low got=%b want=0", en0); else pass_cnt++;
    total++; if (ov0 !== 1'b1 || od0 !== 4'h2 || oa0 !== 4'h0)
      $display("FAIL bp_head got=%b/%h/%h want=1/2/0", ov0, od0, oa0); else pass_cnt++;
    ready = 1'b1;
    #1;
    total++; if (en0 !== 1'b1) $display("FAIL bp_reissue got=%b want=1", en0); else pass_cnt++;
    tick();
    total++; if (od0 !== 4'h2 || oa0 !== 4'h1)
      $display("FAIL bp_second got=%h/%h want=2/1", od0, oa0); else pass_cnt++;
    tick();
    total++; if (ov0 !== 1'b1 || od0 !== 4'hE || oa0 !== 4'h2)
      $display("FAIL bp_third got=%b/%h/%h want=1/E/2", ov0, od0, oa0); else pass_cnt++;
    drain_to_idle();
  endtask

  task automatic test_stop_end;
    ready = 1'b1; start_addr = 4'd14; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    total++; if (ov1 !== 1'b1 || od1 !== 4'hC || oa1 !== 4'hE)
      $display("FAIL se_first got=%b/%h/%h want=1/C/E", ov1, od1, oa1); else pass_cnt++;
    total++; if (en1 !== 1'b0 || ra1 !== 4'h0)
      $display("FAIL se_noissue got=%b/%h want=0/0", en1, ra1); else pass_cnt++;
    tick();
    total++; if (ov1 !== 1'b1 || od1 !== 4'h0 || oa1 !== 4'hF)
      $display("FAIL se_second got=%b/%h/%h want=1/0/F", ov1, od1, oa1); else pass_cnt++;
    total++; if (en1 !== 1'b0 || busy1 !== 1'b1)
      $display("FAIL se_drain got=%b/%b want=0/1", en1, busy1); else pass_cnt++;
    tick();
    total++; if (busy1 !== 1'b0 || ov1 !== 1'b0)
      $display("FAIL se_idle got=%b/%b want=0/0", busy1, ov1); else pass_cnt++;
    total++; if (ov0 !== 1'b1 || od0 !== 4'h2 || oa0 !== 4'h0)
      $display("FAIL wrap_a0 got=%b/%h/%h want=1/2/0", ov0, od0, oa0); else pass_cnt++;
    tick();
    total++; if (ov0 !== 1'b1 || od0 !== 4'h2 || oa0 !== 4'h1)
      $display("FAIL wrap_a1 got=%b/%h/%h want=1/2/1", ov0, od0, oa0); else pass_cnt++;
    drain_to_idle();
  endtask

  task automatic test_redirect;
    ready = 1'b0; start_addr = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    total++; if (ov0 !== 1'b1 || oa0 !== 4'h0)
      $display("FAIL rd_pre got=%b/%h want=1/0", ov0, oa0); else pass_cnt++;
    redirect = 1'b1; redirect_addr = 4'd5; ready = 1'b1;
    tick();
    redirect = 1'b0;
    total++; if (ov0 !== 1'b0 || ra0 !== 4'h5 || en0 !== 1'b1)
      $display("FAIL rd_flush got=%b/%h/%b want=0/5/1", ov0, ra0, en0); else pass_cnt++;
    tick();
    total++; if (ov0 !== 1'b0) $display("FAIL rd_gap got=%b want=0", ov0); else pass_cnt++;
    tick();
    total++; if (ov0 !== 1'b1 || od0 !== 4'hA || oa0 !== 4'h5)
      $display("FAIL rd_new0 got=%b/%h/%h want=1/A/5", ov0, od0, oa0); else pass_cnt++;
    tick();
    total++; if (ov0 !== 1'b1 || od0 !== 4'hC || oa0 !== 4'h6)
      $display("FAIL rd_new1 got=%b/%h/%h want=1/C/6", ov0, od0, oa0); else pass_cnt++;
    drain_to_idle();
  endtask

  task automatic test_halt;
    ready = 1'b1; start_addr = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    total++; if (en0 !== 1'b1 || ra0 !== 4'h2)
      $display("FAIL ht_issue2 got=%b/%h want=1/2", en0, ra0); else pass_cnt++;
    halt = 1'b1;
    tick();
    total++; if (od0 !== 4'h2 || oa0 !== 4'h1 || en0 !== 1'b0)
      $display("FAIL ht_a1 got=%h/%h/%b want=2/1/0", od0, oa0, en0); else pass_cnt++;
    tick();
    total++; if (ov0 !== 1'b1 || od0 !== 4'hE || oa0 !== 4'h2 || busy0 !== 1'b1)
      $display("FAIL ht_a2 got=%b/%h/%h/%b want=1/E/2/1", ov0, od0, oa0, busy0); else pass_cnt++;
    total++; if (en0 !== 1'b0 || ra0 !== 4'h3)
      $display("FAIL ht_noa3 got=%b/%h want=0/3", en0, ra0); else pass_cnt++;
    tick();
    total++; if (busy0 !== 1'b0 || ov0 !== 1'b0)
      $display("FAIL ht_idle got=%b/%b want=0/0", busy0, ov0); else pass_cnt++;
    halt = 1'b0;
  endtask

  task automatic test_idle;
    start = 1'b1; halt = 1'b1; start_addr = 4'd9;
    tick();
    start = 1'b0; halt = 1'b0;
    total++; if (busy0 !== 1'b0 || en0 !== 1'b0 || ra0 !== 4'h3)
      $display("FAIL id_starthalt got=%b/%b/%h want=0/0/3", busy0, en0, ra0); else pass_cnt++;
    redirect = 1'b1; redirect_addr = 4'd9;
    tick();
    redirect = 1'b0;
    total++; if (busy0 !== 1'b0 || en0 !== 1'b0 || ra0 !== 4'h3)
      $display("FAIL id_redirect got=%b/%b/%h want=0/0/3", busy0, en0, ra0); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = 4'd0;
    halt = 1'b0;
    redirect = 1'b0;
    redirect_addr = 4'd0;
    ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stop_end();
    test_redirect();
    test_halt();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/powerpc_rom_fetch.md
# powerpc_rom_fetch

Instruction-fetch sequencer in front of the 16x4 boot ROM. It owns the program counter, drives the ROM's enable and address, and absorbs the ROM's one-cycle read latency. Returned nibbles go into a 2-entry buffer presented to the decode stage over a valid/ready handshake. It supports start, halt/drain, redirect (branch) with flush, and optional stop at end of ROM.

## Interface
- STOP_AT_END, default 0: 1 = stop issuing after address 15 and drain; 0 = wrap 15 -> 0 and continue.
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  pulse; in IDLE loads PC from START_ADDR and enters RUN.
- START_ADDR  in  4  first fetch address.
- HALT  in  1  level/pulse; stop issuing new reads, deliver in-flight data.
- REDIRECT  in  1  pulse; flush buffer and in-flight read, load PC from REDIRECT_ADDR.
- REDIRECT_ADDR  in  4  redirect target.
- ROM_EN  out  1  to ROM ENW.
- ROM_ADDR  out  4  to ROM Addr_A.
- ROM_DATA  in  4  from ROM Data_A; valid the cycle after a sampled ROM_EN=1.
- OUT_VALID  out  1  buffer head valid.
- OUT_READY  in  1  consumer accepts head when OUT_VALID & OUT_READY.
- OUT_DATA  out  4  head nibble.
- OUT_ADDR  out  4  ROM address the head nibble was read from.
- BUSY  out  1  state != IDLE.

## Operation
- Registers: state {IDLE, RUN, DRAIN}, PC[3:0], inflight flag + inflight address, 2-entry FIFO (data+addr), count[1:0].
- ROM_ADDR = PC at all times. ROM_EN = (state==RUN) & (count + inflight - pop < 2), where pop = OUT_VALID & OUT_READY.
- Issue (ROM_EN=1 at an edge): inflight<=1, inflight address<=PC, PC<=PC+1 mod 16.
- Capture: at the edge after an issue, ROM_DATA and the inflight address are pushed to the FIFO tail and inflight<=0, unless a redirect occurs at that edge.
- FIFO: push and pop in the same edge are both honoured, so count is unchanged. Push never occurs while full; this is guaranteed by the credit rule. Order is strictly preserved.
- IDLE: ROM_EN=0. START & !HALT -> RUN, PC<=START_ADDR. REDIRECT is ignored. START with HALT stays in IDLE.
- RUN: HALT -> DRAIN. STOP_AT_END=1 and an issue at PC=15 -> DRAIN, and PC wraps to 0 without further issue. START is ignored.
- DRAIN: no issue. Inflight and FIFO empty out normally. Inflight=0 & count=0 -> IDLE. When the last entry pops, IDLE is entered at that same edge.
- REDIRECT in RUN/DRAIN: at that edge FIFO count<=0, inflight<=0, and PC<=REDIRECT_ADDR. Any read issued in the same cycle is discarded, and any ROM_DATA arriving that cycle is dropped. Next state is DRAIN if HALT is also set (then IDLE on the following edge), otherwise RUN. REDIRECT overrides STOP_AT_END termination and the same-cycle pop.
- HALT during RUN with a read in flight: that nibble is still delivered.

## Timing
- Reset (RST_N=0, asynchronous): state=IDLE, PC=0, count=0, inflight=0. ROM_EN=0, ROM_ADDR=0, OUT_VALID=0, OUT_DATA=0, OUT_ADDR=0, BUSY=0.
- The START edge gives RUN. The first ROM_EN=1 occurs in the following cycle, sampled at edge k. ROM_DATA is valid after edge k and captured at edge k+1. OUT_VALID=1 after edge k+1.
- START to first OUT_VALID is 3 edges. Issue to OUT_VALID is 2 edges.
- With OUT_READY held high, sustained throughput is 1 nibble/cycle.
- With OUT_READY low, at most 2 reads are outstanding (count+inflight ≤ 2), then ROM_EN drops. Reissue happens in the same cycle OUT_READY rises.
- OUT_DATA/OUT_ADDR are stable while OUT_VALID=1 & OUT_READY=0.
- Redirect to first new OUT_VALID is 2 edges after the first post-redirect issue. No pre-redirect data is visible after the REDIRECT edge.

## Test plan
- Reset mid-RUN with 2 entries buffered -> all outputs 0 immediately (asynchronous). Then START_ADDR=0, OUT_READY=1 -> OUT_DATA sequence 2,2,E,2,4,A,C,0 with OUT_ADDR 0..7, one per cycle, first 3 edges after START.
- OUT_READY=0 after START -> ROM_EN pulses exactly twice, then count=2 and ROM_EN=0. Raise OUT_READY -> entries addr0=2, addr1=2 delivered in order, no loss or duplication.
- STOP_AT_END=1, START_ADDR=14 -> outputs (14,C),(15,0), then BUSY falls. No read at address 0. With STOP_AT_END=0 -> continues (0,2),(1,2) after the wrap.
- REDIRECT_ADDR=5 while RUN from 0 with FIFO and inflight occupied -> no nibble from addr ≤3 after the redirect edge. The next outputs are (5,A),(6,C).
- HALT at the edge of issue of addr2 -> addr2 (E) still delivered, no addr3. BUSY drops at the edge its entry pops.
- START+HALT together in IDLE -> stays IDLE, ROM_EN=0. REDIRECT in IDLE -> no effect.
